memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, sets the byte address width of iaddr, daddr and ramaddr.
REQ-002 Parameter WORD_W, default 32, sets the data width of iload, dload, dstore, ramload and ramstore.
REQ-003 CLK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 nRST  in  1  asynchronous, active-low reset.
REQ-005 iREN  in  1  instruction fetch request, held until ihit.
REQ-006 iaddr  in  ADDR_W  fetch address.
REQ-007 ihit  out  1  one-cycle fetch-complete pulse consumed by the hazard unit.
REQ-008 iload  out  WORD_W  fetched instruction, valid only while ihit=1.
REQ-009 dREN / dWEN  in  1 each  data read / write request, held until dhit.
REQ-010 daddr  in  ADDR_W; dstore  in  WORD_W  data request address and write data.
REQ-011 dhit  out  1  one-cycle data-complete pulse; dload  out  WORD_W  read data, valid only while dhit=1.
REQ-012 ramREN / ramWEN  out  1 each; ramaddr  out  ADDR_W; ramstore  out  WORD_W  single-port RAM request.
REQ-013 ramload  in  WORD_W; ramstate  in  2  RAM status: FREE, BUSY, ACCESS, ERROR.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, DREQ and IREQ.
REQ-015 IDLE: if dREN|dWEN, next state DREQ; else if iREN, next state IREQ; else stay IDLE. Data SHALL always have priority.
REQ-016 In IDLE, ramREN, ramWEN, ihit and dhit SHALL all be 0; ramaddr and ramstore SHALL be 0.
REQ-017 DREQ: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN. dWEN SHALL win when dREN and dWEN are both asserted.
REQ-018 IREQ: ramaddr=iaddr, ramREN=1, ramWEN=0.
REQ-019 The current state has hit in a cycle when ramstate=ACCESS and its request is still asserted. That cycle SHALL be the only cycle with dhit=1 (DREQ) or ihit=1 (IREQ), with dload/iload=ramload combinationally, and the next state SHALL be IDLE.
REQ-020 Request dropped: if the current state's request deasserts before ACCESS, the arbiter SHALL return to IDLE next cycle with no hit pulse.
REQ-021 ramstate=ERROR in DREQ/IREQ: return to IDLE with no hit, so the held request is re-arbitrated.
REQ-022 ramstate FREE or BUSY in DREQ/IREQ: hold state and all RAM outputs stable.
REQ-023 Minimum latency: request seen in IDLE at cycle N, hit at N+1, IDLE at N+2. The request line SHALL NOT be re-arbitrated in the same cycle as its own hit.
REQ-024 An in-flight IREQ SHALL NOT be pre-empted by a new data request; that data request is served next from IDLE.

Reset
REQ-025 On nRST=0, state SHALL go to IDLE immediately, including mid-access, and all outputs SHALL go to 0. Any in-flight access SHALL be abandoned without a hit.

Configuration
REQ-026 Macro IHOLD_EN: when defined, a one-entry instruction hold register (valid, addr, data) SHALL be compiled in; when undefined, the register SHALL be absent and ihit SHALL come only from IREQ.
REQ-027 With IHOLD_EN, every RAM ihit SHALL load the hold register with iaddr/ramload and set valid.
REQ-028 With IHOLD_EN, in any state other than IREQ: iREN=1, valid=1 and iaddr=hold addr SHALL give ihit=1 and iload=hold data in the same cycle, with no RAM access. This ihit MAY coincide with dhit.
REQ-029 With IHOLD_EN, a data write hit with daddr equal to the hold address SHALL clear valid. In that same cycle, a hold hit on that address SHALL be suppressed.
REQ-030 With IHOLD_EN, reset SHALL clear valid.

Structure
REQ-031 A shared package SHALL hold the ramstate enum (FREE, BUSY, ACCESS, ERROR), the arbiter state enum and the word_t / addr_t typedefs.
REQ-032 The hold register SHALL be a sub-module ihold_buffer, instantiated only under IHOLD_EN. All other logic SHALL be flat.

Verification
REQ-033 Drive iREN=1, iaddr=0x40 with RAM ACCESS on the 1st cycle and ramload=0x8C010004 -> IREQ at N+1 with ihit=1 and iload=0x8C010004, IDLE at N+2.
REQ-034 Assert dWEN and iREN together with daddr=0x80 and dstore=0xDEADBEEF -> DREQ first, ramWEN=1, dhit pulse; IREQ next; ihit later. No overlap of the two RAM requests.
REQ-035 Hold BUSY for 3 cycles in DREQ, then ACCESS -> RAM outputs stable for 4 cycles and exactly one dhit.
REQ-036 Drive ERROR once in IREQ, then ACCESS -> no ihit after the ERROR, re-entry to IREQ, single ihit.
REQ-037 Pull nRST low while in DREQ with BUSY -> same-cycle IDLE, all outputs 0, no dhit after reset release until a new ACCESS.
REQ-038 With IHOLD_EN, fetch 0x40, refetch 0x40 -> second ihit with no ramREN. Then write daddr=0x40 and refetch -> RAM fetch occurs.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: RAM status, arbiter FSM states and word/address typedefs.
package memory_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int WORD_W_DEF = 32;

  typedef logic [WORD_W_DEF-1:0] word_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DREQ = 2'b01,
    IREQ = 2'b10
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter_ihold.sv
// One-entry instruction hold register (valid, addr, data). Compiled only when IHOLD_EN is defined.
`ifdef IHOLD_EN
module ihold_buffer
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WORD_W-1:0] load_data,
  input  logic              wr_hit,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              lookup,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [WORD_W-1:0] data
);

  logic              valid;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] data_q;
  logic              inv;

  // A store to the held address makes the copy stale in the very cycle it completes.
  assign inv = wr_hit && valid && (wr_addr == addr_q);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (inv) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (load) begin
      addr_q <= load_addr;
      data_q <= load_data;
    end
  end

  assign hit  = lookup && valid && (lookup_addr == addr_q) && !inv;
  assign data = data_q;

endmodule
`endif

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, data first.
// Optional IHOLD_EN macro adds a one-entry instruction hold register (ihold_buffer).
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dhit,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  arb_state_t        state, state_n;
  ramstate_t         rs;
  logic              dreq;
  logic              ram_dhit, ram_ihit;
  logic              hold_hit;
  logic [WORD_W-1:0] hold_data;

  assign rs   = ramstate_t'(ramstate);
  assign dreq = dREN | dWEN;

  // Hits are only valid while the owning request is still held.
  assign ram_dhit = (state == DREQ) && dreq && (rs == ACCESS);
  assign ram_ihit = (state == IREQ) && iREN && (rs == ACCESS);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state)
      IDLE: begin
        if (dreq) begin
          state_n = DREQ;
        end else if (iREN && !hold_hit) begin
          state_n = IREQ;
        end
      end
      DREQ: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!dreq || ram_dhit || rs == ERROR) begin
          state_n = IDLE;
        end
      end
      IREQ: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        if (!iREN || ram_ihit || rs == ERROR) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef IHOLD_EN
  ihold_buffer #(
    .ADDR_W(ADDR_W),
    .WORD_W(WORD_W)
  ) u_ihold (
    .CLK        (CLK),
    .nRST       (nRST),
    .load       (ram_ihit),
    .load_addr  (iaddr),
    .load_data  (ramload),
    .wr_hit     (ram_dhit & dWEN),
    .wr_addr    (daddr),
    .lookup     (iREN && (state != IREQ)),
    .lookup_addr(iaddr),
    .hit        (hold_hit),
    .data       (hold_data)
  );
`else
  assign hold_hit  = 1'b0;
  assign hold_data = '0;
`endif

  assign dhit  = ram_dhit;
  assign dload = ram_dhit ? ramload : '0;
  assign ihit  = ram_ihit | hold_hit;
  assign iload = ram_ihit ? ramload : (hold_hit ? hold_data : '0);

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: vector table plus hand sequences, load data via scoreboard queues.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int WW = 32;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          iREN = 1'b0;
  logic [AW-1:0] iaddr = '0;
  logic          ihit;
  logic [WW-1:0] iload;
  logic          dREN = 1'b0;
  logic          dWEN = 1'b0;
  logic [AW-1:0] daddr = '0;
  logic [WW-1:0] dstore = '0;
  logic          dhit;
  logic [WW-1:0] dload;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [WW-1:0] ramstore;
  logic [WW-1:0] ramload = '0;
  logic [1:0]    ramstate = FREE;

  memory_arbiter #(.ADDR_W(AW), .WORD_W(WW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  int nchk = 0;
  int nerr = 0;
  logic [WW-1:0] dq[$];
  logic [WW-1:0] iq[$];

  typedef struct {
    logic          i;
    logic          dr;
    logic          dw;
    logic [AW-1:0] addr;
    logic [WW-1:0] wdata;
    logic [WW-1:0] rdata;
    int            busy;
    logic          exp_ren;
    logic          exp_wen;
    logic [WW-1:0] exp_store;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " ramREN"}, ramREN, 0);
    chk({tag, " ramWEN"}, ramWEN, 0);
    chk({tag, " ramaddr"}, ramaddr, 0);
    chk({tag, " ramstore"}, ramstore, 0);
    chk({tag, " dhit"}, dhit, 0);
    chk({tag, " ihit"}, ihit, 0);
  endtask

  task automatic sb_check();
    if (dhit) begin
      if (dq.size() == 0) chk("dhit_spurious", dhit, 0);
      else chk("dload", dload, dq.pop_front());
    end
    if (ihit) begin
      if (iq.size() == 0) chk("ihit_spurious", ihit, 0);
      else chk("iload", iload, iq.pop_front());
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    tick();
    iREN = v.i; dREN = v.dr; dWEN = v.dw;
    iaddr = v.addr; daddr = v.addr; dstore = v.wdata;
    ramstate = FREE; ramload = '0;
    #1;
    chk_idle({tag, " idle"});
    if (v.i) iq.push_back(v.rdata);
    else dq.push_back(v.rdata);
    for (int k = 0; k <= v.busy; k++) begin
      tick();
      ramstate = (k == v.busy) ? ACCESS : BUSY;
      ramload = v.rdata;
      #1;
      chk({tag, " ramaddr"}, ramaddr, v.addr);
      chk({tag, " ramREN"}, ramREN, v.exp_ren);
      chk({tag, " ramWEN"}, ramWEN, v.exp_wen);
      chk({tag, " ramstore"}, ramstore, v.exp_store);
      chk({tag, " hit"}, v.i ? ihit : dhit, (k == v.busy));
      chk({tag, " otherhit"}, v.i ? dhit : ihit, 0);
      sb_check();
    end
    tick();
    iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
    #1;
    chk_idle({tag, " after"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_1111, 32'h8C01_0004, 0, 1'b1, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'hA5A5_A5A5, 32'h1234_5678, 0, 1'b1, 1'b0, 32'hA5A5_A5A5};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0104, 32'hCAFE_F00D, 32'h0000_0000, 1, 1'b0, 1'b1, 32'hCAFE_F00D};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_0108, 32'h0BAD_C0DE, 32'h0000_0007, 0, 1'b0, 1'b1, 32'h0BAD_C0DE};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_010C, 32'h0000_0000, 32'h55AA_55AA, 3, 1'b1, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_0050, 32'h0000_2222, 32'h2042_0001, 2, 1'b1, 1'b0, 32'h0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 1'b0, 32'h0};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1'b0, 1'b1, 32'hFFFF_FFFF};

    // Outputs must stay zero while reset is held even with requests pending.
    dREN = 1; daddr = 32'hABC; dstore = 32'h1234; ramstate = ACCESS;
    #1;
    chk_idle("reset");
    tick(); tick();
    dREN = 0; daddr = '0; dstore = '0; ramstate = FREE;
    nRST = 1;
    #1;
    chk_idle("post_reset");

    for (int n = 0; n < 8; n++) run_vec(n, tbl[n]);

    // Data and fetch together: data wins, fetch follows, RAM requests never overlap.
    tick();
    dWEN = 1; iREN = 1; daddr = 32'h80; dstore = 32'hDEAD_BEEF; iaddr = 32'h44; ramstate = FREE;
    #1;
    chk_idle("both idle");
    tick();
    ramstate = ACCESS; ramload = 32'h0000_1357; dq.push_back(32'h0000_1357);
    #1;
    chk("both ramWEN", ramWEN, 1);
    chk("both ramREN", ramREN, 0);
    chk("both ramaddr", ramaddr, 32'h80);
    chk("both ramstore", ramstore, 32'hDEAD_BEEF);
    chk("both dhit", dhit, 1);
    chk("both ihit", ihit, 0);
    sb_check();
    tick();
    dWEN = 0; ramstate = FREE;
    #1;
    chk_idle("both gap");
    tick();
    ramstate = ACCESS; ramload = 32'h2468_0ACE; iq.push_back(32'h2468_0ACE);
    #1;
    chk("both ifetch ramREN", ramREN, 1);
    chk("both ifetch ramWEN", ramWEN, 0);
    chk("both ifetch ramaddr", ramaddr, 32'h44);
    chk("both ifetch ihit", ihit, 1);
    sb_check();
    tick();
    iREN = 0; ramstate = FREE;
    #1;
    chk_idle("both end");

    // ERROR in IREQ drops back to IDLE and the held fetch is re-arbitrated.
    tick();
    iREN = 1; iaddr = 32'h48;
    #1;
    chk_idle("err idle");
    tick();
    ramstate = ERROR; ramload = 32'hBAD0_BAD0;
    #1;
    chk("err ramREN", ramREN, 1);
    chk("err ihit", ihit, 0);
    tick();
    ramstate = FREE;
    #1;
    chk_idle("err back");
    tick();
    ramstate = ACCESS; ramload = 32'h0123_4567; iq.push_back(32'h0123_4567);
    #1;
    chk("err retry ramREN", ramREN, 1);
    chk("err retry ihit", ihit, 1);
    sb_check();
    tick();
    iREN = 0; ramstate = FREE;
    #1;
    chk_idle("err end");

    // Request dropped before ACCESS: no hit, back to IDLE.
    tick();
    dREN = 1; daddr = 32'h200;
    #1;
    chk_idle("drop idle");
    tick();
    ramstate = BUSY;
    #1;
    chk("drop ramREN", ramREN, 1);
    tick();
    dREN = 0; ramstate = ACCESS; ramload = 32'h7777_7777;
    #1;
    chk("drop dhit", dhit, 0);
    tick();
    ramstate = FREE;
    #1;
    chk_idle("drop end");

    // Fetch in flight is not pre-empted by a later data request.
    tick();
    iREN = 1; iaddr = 32'h4C; daddr = 32'h300;
    #1;
    chk_idle("pre idle");
    tick();
    ramstate = BUSY; dREN = 1;
    #1;
    chk("pre ramaddr", ramaddr, 32'h4C);
    chk("pre ramREN", ramREN, 1);
    chk("pre dhit", dhit, 0);
    tick();
    ramstate = ACCESS; ramload = 32'h1111_2222; iq.push_back(32'h1111_2222);
    #1;
    chk("pre ihit", ihit, 1);
    chk("pre ihit dhit", dhit, 0);
    chk("pre ihit ramaddr", ramaddr, 32'h4C);
    sb_check();
    tick();
    iREN = 0; ramstate = FREE;
    #1;
    chk_idle("pre gap");
    tick();
    ramstate = ACCESS; ramload = 32'h3333_4444; dq.push_back(32'h3333_4444);
    #1;
    chk("pre data ramaddr", ramaddr, 32'h300);
    chk("pre data dhit", dhit, 1);
    sb_check();
    tick();
    dREN = 0; ramstate = FREE;
    #1;
    chk_idle("pre end");

    // Reset mid-access abandons the request without a hit.
    tick();
    dREN = 1; daddr = 32'h400; dstore = 32'h5555_AAAA;
    #1;
    chk_idle("rst idle");
    tick();
    ramstate = BUSY;
    #1;
    chk("rst busy ramREN", ramREN, 1);
    #1;
    nRST = 0;
    #1;
    chk_idle("rst asserted");
    tick();
    nRST = 1;
    #1;
    chk_idle("rst released");
    tick();
    #1;
    chk("rst rearb ramREN", ramREN, 1);
    chk("rst rearb dhit", dhit, 0);
    tick();
    #1;
    chk("rst busy dhit", dhit, 0);
    tick();
    ramstate = ACCESS; ramload = 32'h9999_0000; dq.push_back(32'h9999_0000);
    #1;
    chk("rst access dhit", dhit, 1);
    sb_check();
    tick();
    dREN = 0; dstore = '0; ramstate = FREE;
    #1;
    chk_idle("rst end");

`ifdef IHOLD_EN
    begin
      vec_t hv;
      hv = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h8C01_0004, 0, 1'b1, 1'b0, 32'h0};
      run_vec(100, hv);
      tick();
      iREN = 1; iaddr = 32'h40; ramload = 32'hEEEE_EEEE; iq.push_back(32'h8C01_0004);
      #1;
      chk("hold ihit", ihit, 1);
      chk("hold ramREN", ramREN, 0);
      sb_check();
      tick();
      iREN = 0; dWEN = 1; daddr = 32'h40; dstore = 32'h0;
      #1;
      chk("hold wr idle ramWEN", ramWEN, 0);
      tick();
      ramstate = ACCESS; ramload = 32'h0; dq.push_back(32'h0);
      iREN = 1; iaddr = 32'h40;
      #1;
      chk("hold wr dhit", dhit, 1);
      chk("hold wr suppressed ihit", ihit, 0);
      sb_check();
      tick();
      dWEN = 0; ramstate = FREE;
      #1;
      chk("hold inv ihit", ihit, 0);
      chk("hold inv ramREN", ramREN, 0);
      tick();
      ramstate = ACCESS; ramload = 32'h8C01_0008; iq.push_back(32'h8C01_0008);
      #1;
      chk("hold refetch ramREN", ramREN, 1);
      chk("hold refetch ihit", ihit, 1);
      sb_check();
      tick();
      iREN = 0; ramstate = FREE;
      #1;
      chk_idle("hold end");
    end
`endif

    chk("dq_empty", dq.size(), 0);
    chk("iq_empty", iq.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
